smem_lsu: RTL and testbench

Warp-wide load/store sequencer sitting directly upstream of `shared_memory`. Accepts one shared-memory instruction per warp from the issue stage, computes and checks per-lane byte addresses, and issues a single one-cycle multi-lane request when the memory reports ready. It then waits for the response, captures load data, and returns one completion beat per instruction to writeback. It also counts issued operations and bank-conflicting issues for performance reporting.

---
 rtl/pkg_opengpu.sv | 52 +++++
 rtl/smem_addr_gen.sv | 29 ++
 rtl/smem_lsu.sv | 187 ++++++++++++++++++
 tb/tb_smem_lsu.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_opengpu.sv
// Shared types and constants for the shared-memory load/store path.
package pkg_opengpu;

    localparam int WARP_SIZE     = 8;
    localparam int DATA_WIDTH    = 32;
    localparam int SMEM_ADDR_W   = 16;
    // Widest warp tag the op record can carry; the LSU zero-extends narrower tags.
    localparam int WARP_ID_MAX_W = 8;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic [WARP_ID_MAX_W-1:0] warp_id;
        logic [4:0]               rd;
        logic                     we;
        logic [WARP_SIZE-1:0]     mask;
    } smem_lsu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Widen a lane mask so it can gate a flat per-lane data bus.
    function automatic logic [WARP_SIZE*DATA_WIDTH-1:0] lane_data_mask(
        input logic [WARP_SIZE-1:0] m
    );
        logic [WARP_SIZE*DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            r[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{m[i]}};
        end
        return r;
    endfunction

    // Widen a lane mask so it can gate a flat per-lane address bus.
    function automatic logic [WARP_SIZE*SMEM_ADDR_W-1:0] lane_addr_mask(
        input logic [WARP_SIZE-1:0] m
    );
        logic [WARP_SIZE*SMEM_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            r[i*SMEM_ADDR_W +: SMEM_ADDR_W] = {SMEM_ADDR_W{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/smem_addr_gen.sv
// Per-lane shared-memory address generation with alignment and bounds checks.
// The full 32-bit sum is checked so that negative or wrapped addresses fault.
module smem_addr_gen
    import pkg_opengpu::*;
#(
    parameter int SMEM_BYTES = 16384
) (
    input  logic [WARP_SIZE-1:0]             mask,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0]  base,
    input  logic [15:0]                      offset,
    output logic [WARP_SIZE*SMEM_ADDR_W-1:0] addr,
    output logic [WARP_SIZE-1:0]             fault
);

    logic [31:0] sum;

    // Add the sign-extended immediate to each lane base and flag bad lanes.
    always_comb begin
        addr  = '0;
        fault = '0;
        sum   = '0;
        for (int i = 0; i < WARP_SIZE; i++) begin
            sum = base[i*DATA_WIDTH +: DATA_WIDTH] + sext16(offset);
            addr[i*SMEM_ADDR_W +: SMEM_ADDR_W] = sum[SMEM_ADDR_W-1:0];
            fault[i] = mask[i] && ((sum[1:0] != 2'b00) || (sum >= 32'(SMEM_BYTES)));
        end
    end

endmodule

// File: rtl/smem_lsu.sv
// Warp-wide shared-memory load/store sequencer: one instruction in flight,
// one multi-lane request pulse per instruction, one writeback beat per
// instruction, plus op and bank-conflict counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// LSU_IDLE  | ready for an instruction; addresses checked on accept
// LSU_ISSUE | request fields held, pulse fires when memory is ready
// LSU_WAIT  | waiting for response, bounded by RESP_TIMEOUT cycles
// LSU_RESP  | completion beat held until writeback accepts it
module smem_lsu
    import pkg_opengpu::*;
#(
    parameter int SMEM_BYTES   = 16384,
    parameter int WARP_ID_W    = 3,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WARP_ID_W-1:0]             in_warp_id,
    input  logic [4:0]                       in_rd,
    input  logic                             in_we,
    input  logic [WARP_SIZE-1:0]             in_mask,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0]  in_base,
    input  logic [15:0]                      in_offset,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0]  in_wdata,
    output logic [WARP_SIZE-1:0]             smem_req_valid,
    output logic [WARP_SIZE-1:0]             smem_req_we,
    output logic [WARP_SIZE-1:0]             smem_req_mask,
    output logic [WARP_SIZE*SMEM_ADDR_W-1:0] smem_req_addr,
    output logic [WARP_SIZE*DATA_WIDTH-1:0]  smem_req_wdata,
    input  logic                             smem_ready,
    input  logic                             smem_conflict_detected,
    input  logic [WARP_SIZE-1:0]             smem_resp_valid,
    input  logic [WARP_SIZE*DATA_WIDTH-1:0]  smem_resp_rdata,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [WARP_ID_W-1:0]             wb_warp_id,
    output logic [4:0]                       wb_rd,
    output logic                             wb_we,
    output logic [WARP_SIZE-1:0]             wb_mask,
    output logic [WARP_SIZE*DATA_WIDTH-1:0]  wb_data,
    output logic                             wb_fault,
    output logic [WARP_SIZE-1:0]             wb_fault_lanes,
    output logic [31:0]                      stat_ops,
    output logic [31:0]                      stat_conflicts
);

    localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);

    lsu_state_t                       state;
    smem_lsu_op_t                     op_q;
    logic [WARP_SIZE-1:0]             fault_q;
    logic [WARP_SIZE-1:0]             eff_mask;
    logic [WARP_SIZE*SMEM_ADDR_W-1:0] req_addr_q;
    logic [WARP_SIZE*DATA_WIDTH-1:0]  req_wdata_q;
    logic [TMO_W-1:0]                 tmo_cnt;

    logic [WARP_SIZE*SMEM_ADDR_W-1:0] gen_addr;
    logic [WARP_SIZE-1:0]             gen_fault;
    logic [WARP_SIZE-1:0]             gen_eff;
    logic                             issuing;

    smem_addr_gen #(
        .SMEM_BYTES (SMEM_BYTES)
    ) u_addr_gen (
        .mask   (in_mask),
        .base   (in_base),
        .offset (in_offset),
        .addr   (gen_addr),
        .fault  (gen_fault)
    );

    assign gen_eff  = in_mask & ~gen_fault;
    // A timeout folds the live lanes into fault_q, which empties eff_mask.
    assign eff_mask = op_q.mask & ~fault_q;
    assign issuing  = (state == LSU_ISSUE);

    // Request fields are only presented while issuing; the valid pulse
    // additionally waits for the memory to report ready.
    assign smem_req_valid = (issuing && smem_ready) ? eff_mask : '0;
    assign smem_req_mask  = issuing ? eff_mask : '0;
    assign smem_req_we    = issuing ? (eff_mask & {WARP_SIZE{op_q.we}}) : '0;
    assign smem_req_addr  = issuing ? req_addr_q : '0;
    assign smem_req_wdata = issuing ? req_wdata_q : '0;

    // Sequencer: accept, issue, wait with timeout, hold the completion beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LSU_IDLE;
            op_q           <= '0;
            fault_q        <= '0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            tmo_cnt        <= '0;
            in_ready       <= 1'b0;
            wb_valid       <= 1'b0;
            wb_warp_id     <= '0;
            wb_rd          <= '0;
            wb_we          <= 1'b0;
            wb_mask        <= '0;
            wb_data        <= '0;
            wb_fault       <= 1'b0;
            wb_fault_lanes <= '0;
            stat_ops       <= '0;
            stat_conflicts <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready     <= 1'b0;
                        op_q.warp_id <= WARP_ID_MAX_W'(in_warp_id);
                        op_q.rd      <= in_rd;
                        op_q.we      <= in_we;
                        op_q.mask    <= in_mask;
                        fault_q      <= gen_fault;
                        req_addr_q   <= gen_addr & lane_addr_mask(gen_eff);
                        req_wdata_q  <= in_wdata & lane_data_mask(gen_eff);
                        if (gen_eff == '0) begin
                            // Nothing left to send: complete straight away.
                            state          <= LSU_RESP;
                            wb_valid       <= 1'b1;
                            wb_warp_id     <= in_warp_id;
                            wb_rd          <= in_rd;
                            wb_we          <= 1'b0;
                            wb_mask        <= '0;
                            wb_data        <= '0;
                            wb_fault       <= |gen_fault;
                            wb_fault_lanes <= gen_fault;
                        end else begin
                            state <= LSU_ISSUE;
                        end
                    end
                end
                LSU_ISSUE: begin
                    if (smem_ready) begin
                        if (smem_conflict_detected) begin
                            stat_conflicts <= stat_conflicts + 32'd1;
                        end
                        tmo_cnt <= TMO_W'(RESP_TIMEOUT);
                        state   <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    if (smem_resp_valid != '0) begin
                        state          <= LSU_RESP;
                        wb_valid       <= 1'b1;
                        wb_warp_id     <= WARP_ID_W'(op_q.warp_id);
                        wb_rd          <= op_q.rd;
                        wb_we          <= !op_q.we && (eff_mask != '0);
                        wb_mask        <= eff_mask;
                        wb_data        <= op_q.we ? '0
                                        : (smem_resp_rdata & lane_data_mask(eff_mask));
                        wb_fault       <= |fault_q;
                        wb_fault_lanes <= fault_q;
                    end else if (tmo_cnt == TMO_W'(1)) begin
                        state          <= LSU_RESP;
                        fault_q        <= fault_q | eff_mask;
                        wb_valid       <= 1'b1;
                        wb_warp_id     <= WARP_ID_W'(op_q.warp_id);
                        wb_rd          <= op_q.rd;
                        wb_we          <= 1'b0;
                        wb_mask        <= '0;
                        wb_data        <= '0;
                        wb_fault       <= 1'b1;
                        wb_fault_lanes <= fault_q | eff_mask;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                LSU_RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        in_ready <= 1'b1;
                        stat_ops <= stat_ops + 32'd1;
                        state    <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smem_lsu.sv
// Bench for smem_lsu: a simple shared-memory stub plus a lane-level
// reference model of address checking, data return and counters.
module tb_smem_lsu;
    import pkg_opengpu::*;

    localparam int SMEM_BYTES = 16384;
    localparam int WIDW       = 3;
    localparam int TMO        = 64;
    localparam int W          = WARP_SIZE;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDW-1:0]       in_warp_id;
    logic [4:0]            in_rd;
    logic                  in_we;
    logic [W-1:0]          in_mask;
    logic [W*32-1:0]       in_base;
    logic [15:0]           in_offset;
    logic [W*32-1:0]       in_wdata;
    logic [W-1:0]          smem_req_valid;
    logic [W-1:0]          smem_req_we;
    logic [W-1:0]          smem_req_mask;
    logic [W*16-1:0]       smem_req_addr;
    logic [W*32-1:0]       smem_req_wdata;
    logic                  smem_ready;
    logic                  smem_conflict_detected;
    logic [W-1:0]          smem_resp_valid;
    logic [W*32-1:0]       smem_resp_rdata;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [WIDW-1:0]       wb_warp_id;
    logic [4:0]            wb_rd;
    logic                  wb_we;
    logic [W-1:0]          wb_mask;
    logic [W*32-1:0]       wb_data;
    logic                  wb_fault;
    logic [W-1:0]          wb_fault_lanes;
    logic [31:0]           stat_ops;
    logic [31:0]           stat_conflicts;

    smem_lsu #(
        .SMEM_BYTES   (SMEM_BYTES),
        .WARP_ID_W    (WIDW),
        .RESP_TIMEOUT (TMO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_warp_id             (in_warp_id),
        .in_rd                  (in_rd),
        .in_we                  (in_we),
        .in_mask                (in_mask),
        .in_base                (in_base),
        .in_offset              (in_offset),
        .in_wdata               (in_wdata),
        .smem_req_valid         (smem_req_valid),
        .smem_req_we            (smem_req_we),
        .smem_req_mask          (smem_req_mask),
        .smem_req_addr          (smem_req_addr),
        .smem_req_wdata         (smem_req_wdata),
        .smem_ready             (smem_ready),
        .smem_conflict_detected (smem_conflict_detected),
        .smem_resp_valid        (smem_resp_valid),
        .smem_resp_rdata        (smem_resp_rdata),
        .wb_valid               (wb_valid),
        .wb_ready               (wb_ready),
        .wb_warp_id             (wb_warp_id),
        .wb_rd                  (wb_rd),
        .wb_we                  (wb_we),
        .wb_mask                (wb_mask),
        .wb_data                (wb_data),
        .wb_fault               (wb_fault),
        .wb_fault_lanes         (wb_fault_lanes),
        .stat_ops               (stat_ops),
        .stat_conflicts         (stat_conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory seen by the stub, and the model's own copy
    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];

    // stimulus for the next op
    logic        op_we;
    logic [7:0]  op_mask;
    logic [31:0] op_base  [8];
    logic [31:0] op_wdata [8];
    logic [15:0] op_off;
    int          op_hold;
    int          op_rdy_delay;
    bit          respond_en;

    int          model_ops;
    int          model_conf;
    logic [7:0]  obs_fault_lanes;
    logic [255:0] obs_data;

    // memory stub bookkeeping
    int           pulse_cnt;
    logic [7:0]   last_req_mask;
    logic [7:0]   last_req_we;
    logic [127:0] last_req_addr;
    bit           pend;
    logic [7:0]   pend_mask;
    logic [255:0] pend_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 32 banks of 4-byte words: conflict when two live lanes hit one bank at different words
    function automatic bit bank_conflict(input logic [7:0] m, input logic [127:0] ad);
        logic [11:0] wi;
        logic [11:0] wj;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (m[i] && m[j]) begin
                    wi = ad[i*16+2 +: 12];
                    wj = ad[j*16+2 +: 12];
                    if (wi != wj && wi[4:0] == wj[4:0]) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Memory stub: acts #2 after each falling edge; responds one cycle after a request pulse.
    initial begin
        logic [11:0] wi;
        smem_resp_valid        = '0;
        smem_resp_rdata        = '0;
        smem_conflict_detected = 1'b0;
        pend      = 1'b0;
        pend_mask = '0;
        pend_data = '0;
        pulse_cnt = 0;
        last_req_mask = '0;
        last_req_we   = '0;
        last_req_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (pend) begin
                smem_resp_valid = pend_mask;
                smem_resp_rdata = pend_data;
                pend = 1'b0;
            end else begin
                smem_resp_valid = '0;
                smem_resp_rdata = '0;
            end
            if (smem_req_valid != '0) begin
                pulse_cnt++;
                last_req_mask = smem_req_mask;
                last_req_we   = smem_req_we;
                last_req_addr = smem_req_addr;
                smem_conflict_detected = bank_conflict(smem_req_valid, smem_req_addr);
                for (int i = 0; i < 8; i++) begin
                    pend_data[i*32 +: 32] = $urandom;
                    if (smem_req_valid[i]) begin
                        wi = smem_req_addr[i*16+2 +: 12];
                        if (smem_req_we[i]) mem[wi] = smem_req_wdata[i*32 +: 32];
                        else pend_data[i*32 +: 32] = mem[wi];
                    end
                end
                if (respond_en) begin
                    pend      = 1'b1;
                    pend_mask = smem_req_valid;
                end
            end else begin
                smem_conflict_detected = 1'b0;
            end
        end
    end

    task automatic do_op(input string nm);
        logic [31:0]  a;
        logic [11:0]  wi;
        logic [7:0]   flt;
        logic [7:0]   eff0;
        logic [7:0]   effw;
        logic [7:0]   fault_final;
        logic [127:0] eaddr;
        logic [255:0] edata;
        logic [WIDW-1:0] wid;
        logic [4:0]   rd;
        logic [25:0]  snap;
        logic [255:0] snap_d;
        bit           exp_conf;
        int           exp_lat;
        int           lat;
        int           g;
        int           p0;

        flt = '0; eff0 = '0; eaddr = '0; edata = '0;
        for (int i = 0; i < 8; i++) begin
            a = op_base[i] + {{16{op_off[15]}}, op_off};
            if (op_mask[i]) begin
                if (a[1:0] != 2'b00 || a >= SMEM_BYTES) flt[i] = 1'b1;
                else begin
                    eff0[i] = 1'b1;
                    eaddr[i*16 +: 16] = a[15:0];
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (eff0[i] && respond_en) begin
                wi = eaddr[i*16+2 +: 12];
                if (op_we) ref_mem[wi] = op_wdata[i];
                else edata[i*32 +: 32] = ref_mem[wi];
            end
        end
        effw = eff0;
        fault_final = flt;
        if (eff0 != 0 && !respond_en) begin
            fault_final = flt | eff0;
            effw  = '0;
            edata = '0;
        end
        if (op_we) edata = '0;
        if (eff0 == 0) exp_lat = 0;
        else if (respond_en) exp_lat = 2 + op_rdy_delay;
        else exp_lat = TMO + 1 + op_rdy_delay;
        exp_conf = (eff0 != 0) && bank_conflict(eff0, eaddr);
        wid = WIDW'($urandom);
        rd  = 5'($urandom);

        g = 0;
        while (in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_ready_wait"}, in_ready, 1'b1);
        p0 = pulse_cnt;
        in_valid   = 1'b1;
        in_warp_id = wid;
        in_rd      = rd;
        in_we      = op_we;
        in_mask    = op_mask;
        in_offset  = op_off;
        for (int i = 0; i < 8; i++) begin
            in_base[i*32 +: 32]  = op_base[i];
            in_wdata[i*32 +: 32] = op_wdata[i];
        end
        smem_ready = (op_rdy_delay == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_base  = {8{$urandom}};
        chk({nm, "_in_ready_low"}, in_ready, 1'b0);
        lat = 0;
        while (wb_valid !== 1'b1 && lat < 200) begin
            if (lat == op_rdy_delay) smem_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        smem_ready = 1'b1;
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_pulses"}, pulse_cnt - p0, (eff0 != 0) ? 1 : 0);
        if (eff0 != 0) begin
            chk({nm, "_req_mask"}, last_req_mask, eff0);
            chk({nm, "_req_we"}, last_req_we, op_we ? eff0 : 8'h00);
            chk({nm, "_req_addr"}, last_req_addr, eaddr);
        end
        chk({nm, "_wb_warp_id"}, wb_warp_id, wid);
        chk({nm, "_wb_rd"}, wb_rd, rd);
        chk({nm, "_wb_we"}, wb_we, (!op_we && effw != 0));
        chk({nm, "_wb_mask"}, wb_mask, effw);
        chk({nm, "_wb_data"}, wb_data, edata);
        chk({nm, "_wb_fault"}, wb_fault, (fault_final != 0));
        chk({nm, "_wb_fault_lanes"}, wb_fault_lanes, fault_final);
        obs_fault_lanes = wb_fault_lanes;
        obs_data        = wb_data;
        snap   = {wb_warp_id, wb_rd, wb_we, wb_mask, wb_fault, wb_fault_lanes};
        snap_d = wb_data;
        for (int k = 0; k < op_hold; k++) begin
            @(negedge clk);
            chk({nm, "_hold_fields"},
                {wb_valid, in_ready, wb_warp_id, wb_rd, wb_we, wb_mask, wb_fault, wb_fault_lanes},
                {1'b1, 1'b0, snap});
            chk({nm, "_hold_data"}, wb_data, snap_d);
        end
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wb_ready = 1'b0;
        model_ops++;
        if (exp_conf) model_conf++;
        chk({nm, "_wb_done"}, wb_valid, 1'b0);
        chk({nm, "_in_ready_back"}, in_ready, 1'b1);
        chk({nm, "_stat_ops"}, stat_ops, model_ops);
        chk({nm, "_stat_conflicts"}, stat_conflicts, model_conf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  v;
        logic [255:0] exp_b;
        int           r;
        rst_n = 1'b0;
        in_valid = 1'b0; in_warp_id = '0; in_rd = '0; in_we = 1'b0;
        in_mask = '0; in_base = '0; in_offset = '0; in_wdata = '0;
        wb_ready = 1'b0; smem_ready = 1'b1; respond_en = 1'b1;
        model_ops = 0; model_conf = 0;
        op_hold = 0; op_rdy_delay = 0; op_off = '0; op_we = 1'b0; op_mask = '0;
        for (int w = 0; w < 4096; w++) begin
            v = $urandom;
            mem[w] = v;
            ref_mem[w] = v;
        end
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 32'hA000_0000 + i;
            ref_mem[i] = 32'hA000_0000 + i;
            op_wdata[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wb", {wb_valid, wb_we, wb_fault, wb_mask, wb_fault_lanes, wb_rd, wb_warp_id}, '0);
        chk("rst_req", {smem_req_valid, smem_req_mask, smem_req_we, smem_req_addr}, '0);
        chk("rst_stats", {stat_ops, stat_conflicts}, '0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("first_edge_in_ready", in_ready, 1'b1);

        // strided load
        for (int i = 0; i < 8; i++) op_base[i] = 4 * i;
        op_we = 1'b0; op_mask = 8'hFF; op_off = '0;
        do_op("strided");
        chk("strided_lane3", obs_data[3*32 +: 32], 32'hA000_0003);

        // misaligned and out-of-range lanes
        for (int i = 0; i < 8; i++) op_base[i] = 32 + 4 * i;
        op_base[3] = 32'h0000_0101;
        op_base[5] = SMEM_BYTES;
        do_op("misalign");
        chk("misalign_lanes", obs_fault_lanes, 8'h28);

        // all lanes faulted
        op_mask = 8'h01; op_base[0] = 32'h3;
        do_op("allfault");

        // conflicting store then load back
        op_we = 1'b1; op_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            op_base[i]  = 128 * i;
            op_wdata[i] = 32'hB000_0000 + i;
        end
        do_op("cstore");
        chk("cstore_conflicts", stat_conflicts, 32'd1);
        op_we = 1'b0;
        do_op("cload");
        exp_b = '0;
        for (int i = 0; i < 8; i++) exp_b[i*32 +: 32] = 32'hB000_0000 + i;
        chk("cload_data", obs_data, exp_b);

        // writeback backpressure
        for (int i = 0; i < 8; i++) op_base[i] = 256 + 4 * i;
        op_hold = 5;
        do_op("backpressure");

        // randomized ops, with occasional late memory ready
        for (int n = 0; n < 24; n++) begin
            op_we   = ($urandom % 3 == 0);
            op_mask = 8'($urandom);
            r = $urandom % 4;
            op_off  = (r == 0) ? 16'h0000 : (r == 1) ? 16'h0004 : (r == 2) ? 16'hFFFC : 16'h0008;
            for (int i = 0; i < 8; i++) begin
                if (op_we) op_base[i] = 4 * (($urandom % 8) * 8 + i);
                else op_base[i] = 4 * ($urandom % 64);
                r = $urandom % 16;
                if (r == 0) op_base[i] = op_base[i] | 32'h2;
                if (r == 1) op_base[i] = SMEM_BYTES + 4 * i;
                op_wdata[i] = $urandom;
            end
            op_hold      = $urandom % 4;
            op_rdy_delay = $urandom % 3;
            do_op("random");
        end
        op_hold = 0;
        op_rdy_delay = 0;

        // memory never responds
        respond_en = 1'b0;
        op_we = 1'b0; op_mask = 8'hFF; op_off = '0;
        for (int i = 0; i < 8; i++) op_base[i] = 4 * i;
        do_op("timeout");

        // reset while waiting for a response
        in_valid = 1'b1; in_we = 1'b0; in_mask = 8'hFF; in_offset = '0;
        for (int i = 0; i < 8; i++) in_base[i*32 +: 32] = 4 * i;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midop_busy", {in_ready, wb_valid}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_outputs", {in_ready, wb_valid, smem_req_valid}, '0);
        chk("midop_rst_stats", {stat_ops, stat_conflicts}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midop_release_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("midop_after_in_ready", in_ready, 1'b1);
        model_ops  = 0;
        model_conf = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midop_no_beat", wb_valid, 1'b0);
        end
        respond_en = 1'b1;
        do_op("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
